// File: rtl/sync_decoder_2to4.sv
// Registered 2-to-4 one-hot decoder with valid/ready handshake and a
// programmable hold window of HOLD cycles per accepted code.
module sync_decoder_2to4 #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned CW   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] d,
    input  logic       valid,
    output logic       ready,
    output logic [3:0] out,
    output logic       done
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Counter value loaded on acceptance; counts down to zero in the final hold cycle.
    localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [3:0]    out_q,   out_d;
    logic          ready_q, ready_d;
    logic          done_q,  done_d;
    logic          accept;

    // One-hot decode of an encoded select code.
    function automatic logic [3:0] decode(input logic [1:0] code);
        logic [3:0] onehot;
        unique case (code)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            default: onehot = 4'b1000;
        endcase
        return onehot;
    endfunction

    assign accept = valid && ready_q;

    // Next-state, counter and output computation; ready/done derive from next state only.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;

        unique case (state_q)
            IDLE: begin
                out_d = 4'b0000;
                if (accept) begin
                    out_d   = decode(d);
                    cnt_d   = RELOAD;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (accept) begin
                    out_d = decode(d);
                    cnt_d = RELOAD;
                end else begin
                    out_d   = 4'b0000;
                    cnt_d   = CNT_ZERO;
                    state_d = IDLE;
                end
            end
            default: begin
                out_d   = 4'b0000;
                cnt_d   = CNT_ZERO;
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE) || (cnt_d == CNT_ZERO);
        done_d  = (state_d == ACTIVE) && (cnt_d == CNT_ZERO);
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            out_q   <= 4'b0000;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready = ready_q;
    assign out   = out_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sync_decoder_2to4.sv
// Self-checking bench: HOLD=4 and HOLD=1 instances share stimulus; a
// timeline-based model of acceptance windows predicts every output.
module tb_sync_decoder_2to4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [1:0] d;
    logic [3:0] out4, out1;
    logic       ready4, ready1, done4, done1;

    int total = 0;
    int bad   = 0;

    sync_decoder_2to4 #(.HOLD(4), .CW(8)) dut4 (
        .clk(clk), .rst(rst), .d(d), .valid(valid),
        .ready(ready4), .out(out4), .done(done4)
    );

    sync_decoder_2to4 #(.HOLD(1), .CW(8)) dut1 (
        .clk(clk), .rst(rst), .d(d), .valid(valid),
        .ready(ready1), .out(out1), .done(done1)
    );

    always #5 clk = ~clk;

    // Model: each instance remembers its latest accepted code and the edge it
    // was accepted on; outputs follow from where the current cycle falls in
    // that code's HOLD-cycle window.
    int         cyc;
    bit         have   [2];
    int         acc_e  [2];
    logic [1:0] acc_c  [2];
    int         hv     [2];
    bit         armed;

    function automatic bit m_ready(int i, int c);
        return !have[i] || (c >= acc_e[i] + hv[i] - 1);
    endfunction

    function automatic logic [3:0] m_out(int i, int c);
        logic [3:0] one = 4'b0001;
        if (have[i] && c <= acc_e[i] + hv[i] - 1) return one << acc_c[i];
        return 4'b0000;
    endfunction

    function automatic bit m_done(int i, int c);
        return have[i] && (c == acc_e[i] + hv[i] - 1);
    endfunction

    // Highest-set-bit priority encoder, as on the far end of the select bus.
    function automatic logic [1:0] penc(logic [3:0] v);
        for (int b = 3; b >= 0; b--) if (v[b]) return 2'(b);
        return 2'd0;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            bit r = m_ready(i, cyc);
            if (rst) have[i] = 1'b0;
            else if (valid && r) begin
                have[i]  = 1'b1;
                acc_e[i] = cyc + 1;
                acc_c[i] = d;
            end
        end
        if (rst) armed = 1'b1;
        cyc++;
    endtask

    task automatic model_check();
        logic [3:0] o  [2];
        logic       rd [2];
        logic       dn [2];
        o[0] = out4; rd[0] = ready4; dn[0] = done4;
        o[1] = out1; rd[1] = ready1; dn[1] = done1;
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model_out_h%0d", hv[i]),   8'(o[i]),  8'(m_out(i, cyc)));
                chk($sformatf("model_ready_h%0d", hv[i]), 8'(rd[i]), 8'(m_ready(i, cyc)));
                chk($sformatf("model_done_h%0d", hv[i]),  8'(dn[i]), 8'(m_done(i, cyc)));
                chk($sformatf("onehot_h%0d", hv[i]), 8'($countones(o[i]) <= 1), 8'd1);
                if (o[i] != 4'b0000)
                    chk($sformatf("roundtrip_h%0d", hv[i]), 8'(penc(o[i])), 8'(acc_c[i]));
            end
        end
    endtask

    // Apply one cycle of inputs, clock it, then sample away from the edge.
    task automatic step(input logic r, input logic v, input logic [1:0] dd);
        rst = r; valid = v; d = dd;
        @(posedge clk);
        model_update();
        @(negedge clk);
        model_check();
    endtask

    typedef struct {
        logic       rst;
        logic       valid;
        logic [1:0] d;
        logic [3:0] out;
        logic       ready;
        logic       done;
    } vec_t;

    vec_t vt [24];

    initial begin
        logic [3:0] exp1 [4];
        hv[0] = 4; hv[1] = 1;
        have[0] = 1'b0; have[1] = 1'b0;
        acc_e[0] = 0; acc_e[1] = 0;
        acc_c[0] = 2'd0; acc_c[1] = 2'd0;
        cyc = 0; armed = 1'b0;
        rst = 1'b1; valid = 1'b0; d = 2'd0;

        // Constant expectations for the HOLD=4 instance, one row per cycle.
        vt[0]  = '{1'b1, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b0}; // reset, valid ignored
        vt[1]  = '{1'b1, 1'b1, 2'd2, 4'b0000, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 1'b0, 1'b0}; // single transfer
        vt[4]  = '{1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 1'b1};
        vt[7]  = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0}; // back-to-back
        vt[9]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 2'd0, 4'b1000, 1'b1, 1'b1};
        vt[12] = '{1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 1'b0};
        vt[13] = '{1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 1'b0};
        vt[14] = '{1'b0, 1'b1, 2'd1, 4'b0001, 1'b0, 1'b0}; // backpressure
        vt[15] = '{1'b0, 1'b1, 2'd1, 4'b0001, 1'b1, 1'b1};
        vt[16] = '{1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 1'b0};
        vt[17] = '{1'b0, 1'b0, 2'd0, 4'b0010, 1'b0, 1'b0};
        vt[18] = '{1'b1, 1'b1, 2'd3, 4'b0000, 1'b1, 1'b0}; // reset mid-hold
        vt[19] = '{1'b0, 1'b1, 2'd3, 4'b1000, 1'b0, 1'b0};
        vt[20] = '{1'b0, 1'b0, 2'd0, 4'b1000, 1'b0, 1'b0};
        vt[21] = '{1'b1, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
        vt[22] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};
        vt[23] = '{1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 1'b0};

        for (int i = 0; i < 24; i++) begin
            step(vt[i].rst, vt[i].valid, vt[i].d);
            chk($sformatf("vec%0d_out", i),   8'(out4),   8'(vt[i].out));
            chk($sformatf("vec%0d_ready", i), 8'(ready4), 8'(vt[i].ready));
            chk($sformatf("vec%0d_done", i),  8'(done4),  8'(vt[i].done));
        end

        // HOLD=1 stream: a new one-hot value every cycle, done/ready always high.
        exp1[0] = 4'b0001; exp1[1] = 4'b0010; exp1[2] = 4'b0100; exp1[3] = 4'b1000;
        step(1'b1, 1'b0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 2'(i));
            chk($sformatf("h1_stream%0d_out", i), 8'(out1),   8'(exp1[i]));
            chk($sformatf("h1_stream%0d_rdy", i), 8'(ready1), 8'd1);
            chk($sformatf("h1_stream%0d_done", i), 8'(done1), 8'd1);
        end
        step(1'b0, 1'b0, 2'd0);
        chk("h1_stream_idle_out", 8'(out1), 8'd0);
        chk("h1_stream_idle_done", 8'(done1), 8'd0);

        // Randomized traffic against the model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_decoder_2to4.md
# sync_decoder_2to4

Registered 2-to-4 one-hot decoder with a valid/ready handshake and a programmable hold time. It is the companion to the team's 4-to-2 priority encoder, on the other end of the same select interface. It accepts a 2-bit code (d=3 selects out[3]) and drives the matching one-hot line for exactly HOLD cycles. It then returns to all-zero, or switches straight to the next accepted code if one is waiting. Typical use: driving one-hot strobe or select lines from an encoded index.

## Interface
- HOLD, default 4: number of cycles the decoded one-hot output is held per accepted code; legal range 1..255.
- CW, default 8: width of the internal hold counter; must satisfy 2^CW > HOLD-1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- d  input  2  encoded select code; d=3 maps to out[3], d=0 maps to out[0].
- valid  input  1  d is presented for acceptance this cycle.
- ready  output  1  block can accept a code this cycle; transfer happens when valid && ready at a rising edge.
- out  output  4  registered one-hot decode of the accepted code; 4'b0000 when idle.
- done  output  1  high during the final cycle of each hold window.

## Operation
- Reset (rst=1 at an edge):
  - state=IDLE, cnt=0, out=4'b0000, done=0.
  - ready=1 after that edge.
  - valid is ignored in any cycle where rst=1.
- States: IDLE, ACTIVE.
- IDLE:
  - out=0, done=0, ready=1.
  - On valid: latch out <= 1<<d, cnt <= HOLD-1, go to ACTIVE.
- ACTIVE:
  - out holds the latched one-hot value.
  - If cnt!=0: cnt decrements, ready=0, done=0.
  - If cnt==0 (final hold cycle): ready=1, done=1.
- Leaving ACTIVE when cnt==0:
  - valid=1: reload out <= 1<<d, cnt <= HOLD-1, stay in ACTIVE. This is a back-to-back transfer with no zero gap.
  - valid=0: out <= 0, go to IDLE.
- Handshake rules:
  - ready is a function of registered state only; it never depends on valid or d in the same cycle.
  - valid while ready=0 is not accepted.
  - d need not stay stable after acceptance.
- Invariants:
  - out is always either 4'b0000 or exactly one bit set.
  - In ACTIVE, out is never 0.
  - Feeding out into the team's priority encoder returns the accepted d.
- HOLD=1: cnt is always 0 in ACTIVE, so ready=1 and done=1 every ACTIVE cycle. Continuous valid gives a new one-hot output every cycle.
- Counter arithmetic: unsigned, CW bits; decrement only when cnt!=0, so it never wraps.

## Timing
- Acceptance at edge k: out = 1<<d during cycles k+1 .. k+HOLD (exactly HOLD cycles).
- In cycle k+HOLD: done=1 and ready=1.
- Cycle k+HOLD+1:
  - valid=0 at edge k+HOLD: out=0.
  - valid=1 at edge k+HOLD: out = the new code's one-hot value.
- Throughput: one code per HOLD cycles under continuous valid.
- Latency: 1 cycle from accepting edge to out change.
- Reset mid-hold: the edge with rst=1 forces out=0, done=0, ready=1 in the next cycle, regardless of cnt or valid. There is no partial-window completion and no done pulse.
- No combinational path from d or valid to out, ready or done.

## Test plan
- Reset: hold rst=1 for 2 cycles with valid=1, d=2 -> out=0000, done=0, ready=1 after reset; no acceptance occurs.
- Single transfer, HOLD=4: valid=1, d=2 for one cycle at edge k -> out=0100 for cycles k+1..k+4; done=1 and ready=1 only in k+4; out=0000 in k+5.
- Back-to-back, HOLD=4: valid held high with d=3, then d=0 presented at edge k+4 -> out=1000 for 4 cycles, then 0001 for 4 cycles with no 0000 cycle between; ready low in k+1..k+3.
- Backpressure: valid=1, d=1 asserted while ACTIVE with cnt=2 -> code not accepted until ready=1; out stays on the old value; 0010 appears exactly one cycle after the accepting edge.
- HOLD=1 stream: d=0,1,2,3 on consecutive cycles with valid=1 -> out=0001,0010,0100,1000 on the following consecutive cycles; done=1 and ready=1 each ACTIVE cycle.
- Reset mid-hold plus round-trip: accept d=3, assert rst at hold cycle 2 -> out=0000 next cycle, no done. Over random codes, the priority encoder applied to out returns d and out is always one-hot or zero.
